// File: rtl/cpu_run_ctrl_if.sv
// Control/status bundle between a host (board switches, debug logic) and cpu_run_ctrl.
//   master : drives run controls, breakpoint/match setup and core observation inputs
//   slave  : the controller; drives core reset/enable, state, flags and instruction count
interface cpu_run_ctrl_if #(
    parameter int unsigned DIV_W   = 26,
    parameter int unsigned PC_W    = 8,
    parameter int unsigned MATCH_W = 8,
    parameter int unsigned CNT_W   = 16
);
    logic [DIV_W-1:0]   div_value;
    logic               start;
    logic               stop;
    logic               step;
    logic               soft_rst;
    logic               clr_flags;
    logic               bp_en;
    logic [PC_W-1:0]    bp_addr;
    logic [PC_W-1:0]    pc;
    logic               match_en;
    logic [MATCH_W-1:0] match_value;
    logic [MATCH_W-1:0] match_data;

    logic               cpu_rst;
    logic               cpu_en;
    logic [1:0]         state;
    logic               bp_hit;
    logic               match_hit;
    logic [CNT_W-1:0]   instr_count;

    modport master (
        output div_value, start, stop, step, soft_rst, clr_flags,
               bp_en, bp_addr, pc, match_en, match_value, match_data,
        input  cpu_rst, cpu_en, state, bp_hit, match_hit, instr_count
    );

    modport slave (
        input  div_value, start, stop, step, soft_rst, clr_flags,
               bp_en, bp_addr, pc, match_en, match_value, match_data,
        output cpu_rst, cpu_en, state, bp_hit, match_hit, instr_count
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/step controller for the single-cycle LegV8 core. The core runs on the system clock and
// advances only on cycles where cpu_en is high; cpu_en is a clock-enable, never a clock.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : cpu_run_ctrl_if slave (run controls, breakpoint, data match, core reset/enable,
//           state HOLD=0/HALTED=1/RUN=2/STEP=3, sticky flags, saturating instruction count)
module cpu_run_ctrl #(
    parameter int unsigned DIV_W      = 26,
    parameter int unsigned PC_W       = 8,
    parameter int unsigned MATCH_W    = 8,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned RST_CYCLES = 4
) (
    input logic           clk,
    input logic           rst_n,
    cpu_run_ctrl_if.slave bus
);
    localparam int unsigned       HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        StHold   = 2'd0,
        StHalted = 2'd1,
        StRun    = 2'd2,
        StStep   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic               first_tick_q, first_tick_d;
    logic               bp_hit_q, bp_hit_d;
    logic               match_hit_q, match_hit_d;
    logic [CNT_W-1:0]   instr_count_q, instr_count_d;

    logic tick;
    logic pc_eq;
    logic match_eq;
    logic bp_block;
    logic bp_set;
    logic match_set;
    logic leave_halted;
    logic cpu_en;

    assign tick     = (state_q == StRun) && (div_cnt_q == bus.div_value);
    assign pc_eq    = (PC_W'(bus.pc) == PC_W'(bus.bp_addr));
    assign match_eq = (MATCH_W'(bus.match_data) == MATCH_W'(bus.match_value));

    // The first tick after entering RUN is exempt so the core can step off a breakpoint.
    assign bp_block     = tick && !first_tick_q && bus.bp_en && pc_eq;
    assign bp_set       = bp_block && !bus.stop && !bus.soft_rst;
    assign match_set    = (state_q != StHold) && bus.match_en && match_eq;
    assign leave_halted = (state_q == StHalted) && (bus.start || bus.step);

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        div_cnt_d    = '0;
        first_tick_d = first_tick_q;
        cpu_en       = 1'b0;

        unique case (state_q)
            StHold: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = StHalted;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            StHalted: begin
                if (bus.start) begin
                    state_d      = StRun;
                    first_tick_d = 1'b1;
                end else if (bus.step) begin
                    state_d = StStep;
                end
            end
            StRun: begin
                if (bus.stop) begin
                    state_d = StHalted;
                end else if (tick) begin
                    first_tick_d = 1'b0;
                    if (bp_block) begin
                        state_d = StHalted;
                    end else begin
                        cpu_en = 1'b1;
                    end
                end else begin
                    // Wraps through 2^DIV_W-1 if div_value was lowered below the count.
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            StStep: begin
                cpu_en  = 1'b1;
                state_d = StHalted;
            end
            default: state_d = StHold;
        endcase

        if (bus.soft_rst) begin
            state_d    = StHold;
            hold_cnt_d = '0;
            div_cnt_d  = '0;
            cpu_en     = 1'b0;
        end
    end

    always_comb begin
        bp_hit_d      = bp_hit_q;
        match_hit_d   = match_hit_q;
        instr_count_d = instr_count_q;

        // Clears first so a same-cycle set event wins.
        if (bus.clr_flags || leave_halted) bp_hit_d = 1'b0;
        if (bus.clr_flags) match_hit_d = 1'b0;
        if (bp_set) bp_hit_d = 1'b1;
        if (match_set) match_hit_d = 1'b1;

        if (cpu_en && (instr_count_q != CNT_MAX)) instr_count_d = instr_count_q + CNT_W'(1);

        if (state_d == StHold) begin
            bp_hit_d      = 1'b0;
            match_hit_d   = 1'b0;
            instr_count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StHold;
            hold_cnt_q    <= '0;
            div_cnt_q     <= '0;
            first_tick_q  <= 1'b0;
            bp_hit_q      <= 1'b0;
            match_hit_q   <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            div_cnt_q     <= div_cnt_d;
            first_tick_q  <= first_tick_d;
            bp_hit_q      <= bp_hit_d;
            match_hit_q   <= match_hit_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign bus.cpu_rst     = (state_q == StHold);
    assign bus.cpu_en      = cpu_en;
    assign bus.state       = state_q;
    assign bus.bp_hit      = bp_hit_q;
    assign bus.match_hit   = match_hit_q;
    assign bus.instr_count = instr_count_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl. Stimulus pushes expected cpu_en pulse cycles and expected
// status snapshots; a negedge monitor pops and compares them as the cycles are reached.
module tb_cpu_run_ctrl;
    localparam int unsigned DIV_W      = 26;
    localparam int unsigned PC_W       = 8;
    localparam int unsigned MATCH_W    = 8;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned RST_CYCLES = 4;

    localparam int P_START = 0;
    localparam int P_STOP  = 1;
    localparam int P_STEP  = 2;
    localparam int P_SOFT  = 3;
    localparam int P_CLR   = 4;

    localparam int S_STATE = 0;
    localparam int S_RST   = 1;
    localparam int S_BP    = 2;
    localparam int S_MATCH = 3;
    localparam int S_CNT   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   vectors = 0;
    int   fails   = 0;

    typedef struct {
        int          at;
        int          sel;
        logic [31:0] val;
    } chk_t;

    chk_t        chk_q[$];
    int          en_q[$];
    logic [31:0] got;

    cpu_run_ctrl_if #(.DIV_W(DIV_W), .PC_W(PC_W), .MATCH_W(MATCH_W), .CNT_W(CNT_W)) bus ();

    cpu_run_ctrl #(
        .DIV_W      (DIV_W),
        .PC_W       (PC_W),
        .MATCH_W    (MATCH_W),
        .CNT_W      (CNT_W),
        .RST_CYCLES (RST_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] sample(input int sel);
        case (sel)
            S_STATE: return 32'(bus.state);
            S_RST:   return 32'(bus.cpu_rst);
            S_BP:    return 32'(bus.bp_hit);
            S_MATCH: return 32'(bus.match_hit);
            S_CNT:   return 32'(bus.instr_count);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic string sname(input int sel);
        case (sel)
            S_STATE: return "state";
            S_RST:   return "cpu_rst";
            S_BP:    return "bp_hit";
            S_MATCH: return "match_hit";
            S_CNT:   return "instr_count";
            default: return "unknown";
        endcase
    endfunction

    task automatic exp_sig(input int at, input int sel, input logic [31:0] val);
        chk_t c;
        c.at  = at;
        c.sel = sel;
        c.val = val;
        chk_q.push_back(c);
    endtask

    task automatic exp_en(input int at);
        en_q.push_back(at);
    endtask

    // Monitor: every cpu_en pulse must match the next expected pulse cycle, and vice versa.
    always @(negedge clk) begin
        while (en_q.size() > 0 && en_q[0] < cyc) begin
            vectors++;
            fails++;
            $display("FAIL cpu_en_pulse: cycle %0d got no pulse, required cpu_en=1", en_q[0]);
            void'(en_q.pop_front());
        end
        if (bus.cpu_en || (en_q.size() > 0 && en_q[0] == cyc)) begin
            vectors++;
            if (bus.cpu_en && en_q.size() > 0 && en_q[0] == cyc) begin
                void'(en_q.pop_front());
            end else begin
                fails++;
                $display("FAIL cpu_en_pulse: cycle %0d got cpu_en=%0b, required %0b",
                         cyc, bus.cpu_en, !bus.cpu_en);
                if (en_q.size() > 0 && en_q[0] == cyc) void'(en_q.pop_front());
            end
        end
        for (int i = chk_q.size() - 1; i >= 0; i--) begin
            if (chk_q[i].at == cyc) begin
                vectors++;
                got = sample(chk_q[i].sel);
                if (got !== chk_q[i].val) begin
                    fails++;
                    $display("FAIL %s: cycle %0d got %0d, required %0d",
                             sname(chk_q[i].sel), cyc, got, chk_q[i].val);
                end
                chk_q.delete(i);
            end
        end
    end

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step_clk();
    endtask

    task automatic set_ctl(input int which, input logic v);
        case (which)
            P_START: bus.start     = v;
            P_STOP:  bus.stop      = v;
            P_STEP:  bus.step      = v;
            P_SOFT:  bus.soft_rst  = v;
            P_CLR:   bus.clr_flags = v;
            default: ;
        endcase
    endtask

    // One-cycle pulse; e is the cycle number seen right after the sampling edge.
    task automatic pulse(input int which, output int e);
        set_ctl(which, 1'b1);
        e = cyc + 1;
        step_clk();
        set_ctl(which, 1'b0);
    endtask

    initial begin
        int r, e, s, m, c;

        bus.div_value   = 26'd3;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.step        = 1'b0;
        bus.soft_rst    = 1'b0;
        bus.clr_flags   = 1'b0;
        bus.bp_en       = 1'b0;
        bus.bp_addr     = 8'h10;
        bus.pc          = 8'h00;
        bus.match_en    = 1'b0;
        bus.match_value = 8'h0F;
        bus.match_data  = 8'h00;

        // Reset hold
        #1 rst_n = 1'b0;
        repeat (3) step_clk();
        rst_n = 1'b1;
        r = cyc;
        exp_sig(r, S_STATE, 0);
        exp_sig(r, S_RST, 1);
        exp_sig(r, S_CNT, 0);
        exp_sig(r, S_BP, 0);
        exp_sig(r, S_MATCH, 0);
        exp_sig(r + 3, S_STATE, 0);
        exp_sig(r + 3, S_RST, 1);
        exp_sig(r + 4, S_STATE, 1);
        exp_sig(r + 4, S_RST, 0);
        wait_until(r + 4);

        // Run with div_value=3: ticks every 4 cycles
        pulse(P_START, e);
        exp_sig(e, S_STATE, 2);
        exp_en(e + 3);
        exp_en(e + 7);
        exp_en(e + 11);
        exp_sig(e + 12, S_CNT, 3);
        wait_until(e + 12);
        pulse(P_STOP, s);
        exp_sig(s, S_STATE, 1);
        exp_sig(s, S_CNT, 3);

        // Stop coincident with a tick suppresses the enable
        pulse(P_START, e);
        wait_until(e + 3);
        pulse(P_STOP, s);
        exp_sig(s, S_STATE, 1);
        exp_sig(s, S_CNT, 3);

        // div_value=0: enable every cycle
        bus.div_value = 26'd0;
        pulse(P_START, e);
        for (int i = 0; i < 4; i++) exp_en(e + i);
        wait_until(e + 4);
        pulse(P_STOP, s);
        exp_sig(s, S_STATE, 1);
        exp_sig(s, S_CNT, 7);
        bus.div_value = 26'd3;

        // Three single steps, 5 cycles apart
        for (int i = 0; i < 3; i++) begin
            pulse(P_STEP, e);
            exp_en(e);
            exp_sig(e, S_STATE, 3);
            exp_sig(e + 1, S_STATE, 1);
            if (i == 2) exp_sig(e + 1, S_CNT, 10);
            repeat (4) step_clk();
        end

        // Breakpoint: first tick exempt, second blocked
        bus.bp_en = 1'b1;
        pulse(P_START, e);
        exp_en(e + 3);
        wait_until(e + 4);
        bus.pc = 8'h10;
        exp_sig(e + 8, S_STATE, 1);
        exp_sig(e + 8, S_BP, 1);
        exp_sig(e + 8, S_CNT, 11);
        wait_until(e + 8);
        pulse(P_START, e);
        exp_sig(e, S_BP, 0);
        exp_sig(e, S_STATE, 2);
        exp_en(e + 3);
        exp_sig(e + 8, S_STATE, 1);
        exp_sig(e + 8, S_BP, 1);
        exp_sig(e + 8, S_CNT, 12);
        wait_until(e + 8);
        pulse(P_CLR, c);
        exp_sig(c, S_BP, 0);
        bus.bp_en = 1'b0;
        bus.pc    = 8'h00;

        // Sticky data match, set wins over clear
        bus.match_en   = 1'b1;
        m              = cyc;
        bus.match_data = 8'h0F;
        step_clk();
        bus.match_data = 8'h00;
        exp_sig(m + 1, S_MATCH, 1);
        exp_sig(m + 5, S_MATCH, 1);
        wait_until(m + 5);
        bus.match_data = 8'h0F;
        pulse(P_CLR, c);
        bus.match_data = 8'h00;
        exp_sig(c, S_MATCH, 1);
        pulse(P_CLR, c);
        exp_sig(c, S_MATCH, 0);
        bus.match_en = 1'b0;

        // 20 steps saturate a 4-bit counter at 15
        for (int i = 0; i < 20; i++) begin
            pulse(P_STEP, e);
            exp_en(e);
            if (i == 19) begin
                exp_sig(e + 1, S_CNT, 15);
                exp_sig(e + 1, S_STATE, 1);
            end
            step_clk();
        end

        // Soft reset with a tick pending
        pulse(P_START, e);
        wait_until(e + 3);
        pulse(P_SOFT, s);
        exp_sig(s, S_STATE, 0);
        exp_sig(s, S_CNT, 0);
        exp_sig(s, S_RST, 1);
        exp_sig(s + 3, S_RST, 1);
        exp_sig(s + 3, S_STATE, 0);
        exp_sig(s + 4, S_STATE, 1);
        exp_sig(s + 4, S_RST, 0);
        wait_until(s + 6);

        foreach (chk_q[i]) begin
            vectors++;
            fails++;
            $display("FAIL %s: cycle %0d never checked, required %0d",
                     sname(chk_q[i].sel), chk_q[i].at, chk_q[i].val);
        end
        foreach (en_q[i]) begin
            vectors++;
            fails++;
            $display("FAIL cpu_en_pulse: cycle %0d got no pulse, required cpu_en=1", en_q[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
